// File: rtl/mat_pkg.sv
// Shared constants and FSM state type for the matrix row store.
package mat_pkg;

  localparam int DEF_SIZE  = 4;
  localparam int DEF_WIDTH = 64;
  localparam int DEF_ROW_W = DEF_SIZE * 2 * DEF_WIDTH;
  localparam int DEF_AW    = $clog2(DEF_SIZE);

  typedef enum logic {
    IDLE = 1'b0,
    DUMP = 1'b1
  } state_e;

endpackage

// File: rtl/mat_row_store.sv
// SIZE-row complex-matrix store: host load, compute read/writeback and a streaming row dump.
// Define MAT_ROW_STORE_BYPASS_EN to forward same-cycle write/load data to a colliding read.
module mat_row_store
  import mat_pkg::*;
#(
  parameter  int SIZE  = DEF_SIZE,
  parameter  int WIDTH = DEF_WIDTH,
  localparam int ROW_W = SIZE * 2 * WIDTH,
  localparam int AW    = $clog2(SIZE)
) (
  input  logic             clk_i,
  input  logic             rst_i,

  input  logic [ROW_W-1:0] load_row_i,
  input  logic [AW-1:0]    load_addr_i,
  input  logic             load_valid_i,
  output logic             load_ready_o,

  input  logic [AW-1:0]    rd_addr_i,
  input  logic             rd_addr_valid_i,
  output logic [ROW_W-1:0] rd_row_o,
  output logic [AW-1:0]    rd_addr_o,
  output logic             rd_valid_o,

  input  logic [ROW_W-1:0] wr_row_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic             wr_valid_i,
  output logic             wr_ready_o,

  input  logic             dump_start_i,
  input  logic             dump_ready_i,
  input  logic             flush_i,
  output logic [ROW_W-1:0] dump_row_o,
  output logic [AW-1:0]    dump_addr_o,
  output logic             dump_valid_o,
  output logic             busy_o
);

  state_e           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [ROW_W-1:0] mem_q [SIZE];
  logic [ROW_W-1:0] rd_row_q, rd_row_d;
  logic [AW-1:0]    rd_addr_q;
  logic             rd_valid_q;
  logic             in_idle;
  logic             wr_fire;
  logic             load_fire;

  assign in_idle   = (state_q == IDLE);
  // Flush drops whatever write or load is presented alongside it.
  assign wr_fire   = wr_valid_i & in_idle & ~flush_i;
  assign load_fire = load_valid_i & in_idle & ~wr_valid_i & ~flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (dump_start_i) begin
            state_d = DUMP;
            cnt_d   = '0;
          end
        end
        DUMP: begin
          if (dump_ready_i) begin
            if (cnt_q == AW'(SIZE - 1)) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    rd_row_d = mem_q[rd_addr_i];
`ifdef MAT_ROW_STORE_BYPASS_EN
    if (wr_fire && (wr_addr_i == rd_addr_i)) begin
      rd_row_d = wr_row_i;
    end else if (load_fire && (load_addr_i == rd_addr_i)) begin
      rd_row_d = load_row_i;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_row_q   <= '0;
      rd_addr_q  <= '0;
      rd_valid_q <= 1'b0;
      for (int i = 0; i < SIZE; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_valid_q <= rd_addr_valid_i;
      if (rd_addr_valid_i) begin
        rd_row_q  <= rd_row_d;
        rd_addr_q <= rd_addr_i;
      end
      if (wr_fire) begin
        mem_q[wr_addr_i] <= wr_row_i;
      end else if (load_fire) begin
        mem_q[load_addr_i] <= load_row_i;
      end
    end
  end

  // Outputs are forced to their reset values combinationally while rst_i is high.
  assign wr_ready_o   = rst_i | in_idle;
  assign load_ready_o = rst_i | (in_idle & ~wr_valid_i);
  assign rd_valid_o   = rd_valid_q & ~rst_i;
  assign rd_row_o     = rst_i ? '0 : rd_row_q;
  assign rd_addr_o    = rst_i ? '0 : rd_addr_q;
  assign dump_valid_o = ~rst_i & (state_q == DUMP);
  assign dump_addr_o  = dump_valid_o ? cnt_q : '0;
  assign dump_row_o   = dump_valid_o ? mem_q[cnt_q] : '0;
  assign busy_o       = ~rst_i & ((state_q == DUMP) | rd_valid_q);

endmodule

// File: tb/tb_mat_row_store.sv
// Self-checking bench for mat_row_store: directed corner sequences plus a randomized model run.
module tb_mat_row_store;

  localparam int SIZE  = 4;
  localparam int WIDTH = 64;
  localparam int ROW_W = SIZE * 2 * WIDTH;
  localparam int AW    = $clog2(SIZE);
`ifdef MAT_ROW_STORE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef logic [ROW_W-1:0] row_t;
  typedef logic [AW-1:0]    addr_t;

  typedef struct {
    logic  rd_v;
    addr_t rd_a;
    row_t  exp_row;
    addr_t exp_addr;
    logic  exp_valid;
    logic  exp_busy;
  } rd_vec_t;

  logic  clk_i = 1'b0;
  logic  rst_i;
  row_t  load_row_i;
  addr_t load_addr_i;
  logic  load_valid_i;
  logic  load_ready_o;
  addr_t rd_addr_i;
  logic  rd_addr_valid_i;
  row_t  rd_row_o;
  addr_t rd_addr_o;
  logic  rd_valid_o;
  row_t  wr_row_i;
  addr_t wr_addr_i;
  logic  wr_valid_i;
  logic  wr_ready_o;
  logic  dump_start_i;
  logic  dump_ready_i;
  logic  flush_i;
  row_t  dump_row_o;
  addr_t dump_addr_o;
  logic  dump_valid_o;
  logic  busy_o;

  int   n_tests = 0;
  int   n_fail  = 0;
  row_t model_mem [SIZE];

  always #5 clk_i = ~clk_i;

  mat_row_store #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .load_row_i(load_row_i), .load_addr_i(load_addr_i), .load_valid_i(load_valid_i),
    .load_ready_o(load_ready_o),
    .rd_addr_i(rd_addr_i), .rd_addr_valid_i(rd_addr_valid_i),
    .rd_row_o(rd_row_o), .rd_addr_o(rd_addr_o), .rd_valid_o(rd_valid_o),
    .wr_row_i(wr_row_i), .wr_addr_i(wr_addr_i), .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
    .dump_start_i(dump_start_i), .dump_ready_i(dump_ready_i), .flush_i(flush_i),
    .dump_row_o(dump_row_o), .dump_addr_o(dump_addr_o), .dump_valid_o(dump_valid_o),
    .busy_o(busy_o)
  );

  function automatic row_t pat(input int i);
    row_t r;
    r = '0;
    for (int k = 0; k < ROW_W / 32; k++) r[k*32 +: 32] = 32'(32'h1000_0000 * (i + 1) + k);
    return r;
  endfunction

  function automatic row_t rand_row();
    row_t r;
    r = '0;
    for (int k = 0; k < ROW_W / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_row(input string nm, input row_t act, input row_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_bit(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b want %0b", nm, act, exp);
    end
  endtask

  task automatic chk_addr(input string nm, input addr_t act, input addr_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic rd_check(input string nm, input addr_t a, input row_t exp);
    rd_addr_i       = a;
    rd_addr_valid_i = 1'b1;
    tick();
    rd_addr_valid_i = 1'b0;
    chk_bit({nm, "_valid"}, rd_valid_o, 1'b1);
    chk_row({nm, "_row"}, rd_row_o, exp);
  endtask

  task automatic clear_inputs();
    load_row_i = '0; load_addr_i = '0; load_valid_i = 1'b0;
    rd_addr_i = '0; rd_addr_valid_i = 1'b0;
    wr_row_i = '0; wr_addr_i = '0; wr_valid_i = 1'b0;
    dump_start_i = 1'b0; dump_ready_i = 1'b0; flush_i = 1'b0;
  endtask

  rd_vec_t rv [5];
  int      rdy_seq [6];

  initial begin
    row_t  w_row, l_row, a5_row, nrow;
    int    idx;
    logic  m_dump;
    int    m_idx;
    logic  e_valid;
    row_t  e_row;
    addr_t e_addr;
    logic  wc, lc;

    clear_inputs();
    rst_i = 1'b1;
    tick();
    chk_bit("rst_load_ready", load_ready_o, 1'b1);
    chk_bit("rst_wr_ready", wr_ready_o, 1'b1);
    chk_bit("rst_dump_valid", dump_valid_o, 1'b0);
    chk_bit("rst_busy", busy_o, 1'b0);
    chk_bit("rst_rd_valid", rd_valid_o, 1'b0);
    chk_row("rst_rd_row", rd_row_o, '0);
    rst_i = 1'b0;
    for (int i = 0; i < SIZE; i++) model_mem[i] = '0;
    tick();

    // Fill rows 0..3
    for (int i = 0; i < SIZE; i++) begin
      load_valid_i = 1'b1;
      load_addr_i  = addr_t'(i);
      load_row_i   = pat(i);
      #1;
      chk_bit("fill_load_ready", load_ready_o, 1'b1);
      tick();
      model_mem[i] = pat(i);
    end
    load_valid_i = 1'b0;

    // Back-to-back reads 3,0,2 then idle cycles holding the last response
    rv[0] = '{1'b1, 2'd3, pat(3), 2'd3, 1'b1, 1'b1};
    rv[1] = '{1'b1, 2'd0, pat(0), 2'd0, 1'b1, 1'b1};
    rv[2] = '{1'b1, 2'd2, pat(2), 2'd2, 1'b1, 1'b1};
    rv[3] = '{1'b0, 2'd0, pat(2), 2'd2, 1'b0, 1'b0};
    rv[4] = '{1'b0, 2'd1, pat(2), 2'd2, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      rd_addr_valid_i = rv[i].rd_v;
      rd_addr_i       = rv[i].rd_a;
      tick();
      chk_bit("tbl_rd_valid", rd_valid_o, rv[i].exp_valid);
      chk_row("tbl_rd_row", rd_row_o, rv[i].exp_row);
      chk_addr("tbl_rd_addr", rd_addr_o, rv[i].exp_addr);
      chk_bit("tbl_busy", busy_o, rv[i].exp_busy);
    end
    rd_addr_valid_i = 1'b0;

    // Write beats load to the same address; load retried next cycle
    w_row = pat(10);
    l_row = pat(11);
    wr_valid_i = 1'b1; wr_addr_i = 2'd1; wr_row_i = w_row;
    load_valid_i = 1'b1; load_addr_i = 2'd1; load_row_i = l_row;
    #1;
    chk_bit("prio_load_ready", load_ready_o, 1'b0);
    chk_bit("prio_wr_ready", wr_ready_o, 1'b1);
    tick();
    wr_valid_i = 1'b0;
    rd_addr_i = 2'd1; rd_addr_valid_i = 1'b1;
    #1;
    chk_bit("prio_retry_ready", load_ready_o, 1'b1);
    tick();
    load_valid_i = 1'b0; rd_addr_valid_i = 1'b0;
    chk_row("prio_wr_stored", rd_row_o, BYP ? l_row : w_row);
    rd_check("prio_load_stored", 2'd1, l_row);
    model_mem[1] = l_row;

    // Same-cycle read/write collision
    a5_row = {(ROW_W/8){8'hA5}};
    wr_valid_i = 1'b1; wr_addr_i = 2'd2; wr_row_i = a5_row;
    rd_addr_i = 2'd2; rd_addr_valid_i = 1'b1;
    tick();
    wr_valid_i = 1'b0; rd_addr_valid_i = 1'b0;
    chk_row("coll_rd_row", rd_row_o, BYP ? a5_row : pat(2));
    rd_check("coll_after", 2'd2, a5_row);
    model_mem[2] = a5_row;

    // Dump with backpressure; a write and a restart during the dump are ignored
    rdy_seq = '{1, 0, 0, 1, 1, 1};
    dump_start_i = 1'b1;
    tick();
    dump_start_i = 1'b0;
    idx = 0;
    for (int k = 0; k < 6; k++) begin
      dump_start_i = (k == 1);
      wr_valid_i   = (k == 2);
      wr_addr_i    = 2'd3;
      wr_row_i     = pat(30);
      dump_ready_i = (rdy_seq[k] != 0);
      #1;
      chk_bit("dump_valid", dump_valid_o, 1'b1);
      chk_addr("dump_addr", dump_addr_o, addr_t'(idx));
      chk_row("dump_row", dump_row_o, model_mem[idx]);
      chk_bit("dump_wr_ready", wr_ready_o, 1'b0);
      chk_bit("dump_busy", busy_o, 1'b1);
      tick();
      if (rdy_seq[k] != 0) idx++;
    end
    clear_inputs();
    chk_bit("dump_end_valid", dump_valid_o, 1'b0);
    chk_bit("dump_end_wr_ready", wr_ready_o, 1'b1);
    rd_check("dump_wr_dropped", 2'd3, pat(3));

    // Flush after row 1 accepted; flush in IDLE drops a write
    dump_start_i = 1'b1;
    tick();
    dump_start_i = 1'b0; dump_ready_i = 1'b1;
    tick();
    tick();
    dump_ready_i = 1'b0; flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk_bit("flush_dump_valid", dump_valid_o, 1'b0);
    flush_i = 1'b1; wr_valid_i = 1'b1; wr_addr_i = 2'd0; wr_row_i = pat(20);
    tick();
    clear_inputs();
    for (int i = 0; i < SIZE; i++) rd_check("flush_intact", addr_t'(i), model_mem[i]);
    dump_start_i = 1'b1;
    tick();
    dump_start_i = 1'b0;
    #1;
    chk_bit("redump_valid", dump_valid_o, 1'b1);
    chk_addr("redump_addr", dump_addr_o, 2'd0);
    chk_row("redump_row", dump_row_o, model_mem[0]);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;

    // Reset mid-dump
    dump_start_i = 1'b1;
    tick();
    dump_start_i = 1'b0; dump_ready_i = 1'b1;
    tick();
    dump_ready_i = 1'b0; rst_i = 1'b1;
    #1;
    chk_bit("rstd_cycle_valid", dump_valid_o, 1'b0);
    tick();
    rst_i = 1'b0;
    for (int i = 0; i < SIZE; i++) model_mem[i] = '0;
    chk_bit("rstd_dump_valid", dump_valid_o, 1'b0);
    chk_bit("rstd_busy", busy_o, 1'b0);
    chk_bit("rstd_load_ready", load_ready_o, 1'b1);
    chk_bit("rstd_wr_ready", wr_ready_o, 1'b1);
    for (int i = 0; i < SIZE; i++) rd_check("rstd_zero", addr_t'(i), '0);

    // Randomized run against a behavioural model
    m_dump = 1'b0; m_idx = 0;
    e_valid = 1'b0; e_row = '0; e_addr = addr_t'(SIZE - 1);
    tick();
    for (int c = 0; c < 400; c++) begin
      wr_valid_i      = ($urandom_range(0, 3) == 0);
      wr_addr_i       = addr_t'($urandom_range(0, SIZE - 1));
      wr_row_i        = rand_row();
      load_valid_i    = ($urandom_range(0, 2) == 0);
      load_addr_i     = addr_t'($urandom_range(0, SIZE - 1));
      load_row_i      = rand_row();
      rd_addr_valid_i = 1'($urandom_range(0, 1));
      rd_addr_i       = addr_t'($urandom_range(0, SIZE - 1));
      dump_start_i    = ($urandom_range(0, 7) == 0);
      dump_ready_i    = 1'($urandom_range(0, 1));
      flush_i         = ($urandom_range(0, 31) == 0);
      #1;
      chk_bit("rnd_dump_valid", dump_valid_o, m_dump);
      if (m_dump) begin
        chk_addr("rnd_dump_addr", dump_addr_o, addr_t'(m_idx));
        chk_row("rnd_dump_row", dump_row_o, model_mem[m_idx]);
      end
      chk_bit("rnd_wr_ready", wr_ready_o, !m_dump);
      chk_bit("rnd_load_ready", load_ready_o, !m_dump && !wr_valid_i);

      wc = wr_valid_i && !m_dump && !flush_i;
      lc = load_valid_i && !m_dump && !wr_valid_i && !flush_i;
      e_valid = rd_addr_valid_i;
      if (rd_addr_valid_i) begin
        nrow = model_mem[rd_addr_i];
        if (BYP && wc && wr_addr_i == rd_addr_i) nrow = wr_row_i;
        else if (BYP && lc && load_addr_i == rd_addr_i) nrow = load_row_i;
        e_row  = nrow;
        e_addr = rd_addr_i;
      end
      if (wc) model_mem[wr_addr_i] = wr_row_i;
      else if (lc) model_mem[load_addr_i] = load_row_i;
      if (flush_i) begin
        m_dump = 1'b0; m_idx = 0;
      end else if (m_dump && dump_ready_i) begin
        if (m_idx == SIZE - 1) begin
          m_dump = 1'b0; m_idx = 0;
        end else begin
          m_idx++;
        end
      end else if (!m_dump && dump_start_i) begin
        m_dump = 1'b1; m_idx = 0;
      end

      tick();
      chk_bit("rnd_rd_valid", rd_valid_o, e_valid);
      chk_row("rnd_rd_row", rd_row_o, e_row);
      chk_addr("rnd_rd_addr", rd_addr_o, e_addr);
      chk_bit("rnd_busy", busy_o, m_dump || e_valid);
    end
    clear_inputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
